// File: rtl/pcpi_mul_pkg.sv
// Shared decode constants, state/op enums and step width for the PCPI
// sequential multiplier. SEQ_MUL_2BIT_EN selects two multiplier bits per cycle.
package pcpi_mul_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;
    localparam logic [2:0] F3_MUL     = 3'b000;
    localparam logic [2:0] F3_MULH    = 3'b001;
    localparam logic [2:0] F3_MULHSU  = 3'b010;
    localparam logic [2:0] F3_MULHU   = 3'b011;

`ifdef SEQ_MUL_2BIT_EN
    localparam int STEP_BITS = 2;
`else
    localparam int STEP_BITS = 1;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU} op_t;

    // funct3[1:0] maps directly onto the op enum ordering
    function automatic op_t f3_to_op(input logic [1:0] f3);
        return op_t'(f3);
    endfunction
endpackage

// File: rtl/seq_mul_dp.sv
// Shift-add datapath: multiplier, multiplicand and accumulator registers.
// SEQ_MUL_2BIT_EN retires two multiplier bits per step.
module seq_mul_dp
    import pcpi_mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              step,
    input  logic              sext_a,
    input  logic              sext_b,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc
);
    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] mplier;
    logic [2*XLEN-1:0] addend;

    // partial product for the multiplier bit(s) currently at the bottom
    always_comb begin
        addend = '0;
`ifdef SEQ_MUL_2BIT_EN
        addend = (mplier[0] ? mcand : '0) + (mplier[1] ? {mcand[2*XLEN-2:0], 1'b0} : '0);
`else
        addend = mplier[0] ? mcand : '0;
`endif
    end

    // load extended operands, then accumulate and shift each step;
    // the multiplier shifts right so its low bit(s) track multiplier[ctr]
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= {{XLEN{sext_a & a[XLEN-1]}}, a};
            mplier <= {{XLEN{sext_b & b[XLEN-1]}}, b};
            acc    <= '0;
        end else if (step) begin
            acc    <= acc + addend;
            mcand  <= mcand << STEP_BITS;
            mplier <= mplier >> STEP_BITS;
        end
    end
endmodule

// File: rtl/pcpi_seq_mul.sv
// PCPI front-end for the sequential shift-add multiplier: decodes RV32M
// MUL/MULH/MULHSU/MULHU, sequences seq_mul_dp, returns the selected half.
// SEQ_MUL_2BIT_EN halves the RUN length (two bits per cycle).
module pcpi_seq_mul
    import pcpi_mul_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CTR_W = $clog2(2*XLEN)+1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            pcpi_valid,
    input  logic [31:0]     pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic            pcpi_wait,
    output logic            pcpi_ready
);
    state_t            state, next_state;
    op_t               dec_op, op_q;
    logic [CTR_W-1:0]  ctr;
    logic [2*XLEN-1:0] acc;
    logic              hit, last, load, step, sext_a, sext_b;
    logic              unused_insn_bits;

    assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    assign hit    = (pcpi_insn[6:0] == OPC_OP) && (pcpi_insn[31:25] == F7_MULDIV) && !pcpi_insn[14];
    assign dec_op = f3_to_op(pcpi_insn[13:12]);
    assign last   = (ctr == CTR_W'(2*XLEN - STEP_BITS));
    assign load   = (state == IDLE) && pcpi_valid && hit;
    assign step   = (state == RUN) && pcpi_valid;
    assign sext_a = (dec_op != OP_MULHU);
    assign sext_b = (dec_op == OP_MUL) || (dec_op == OP_MULH);

    // next state: accept a decoded op, abort on dropped valid, one-cycle DONE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pcpi_valid && hit) next_state = RUN;
            RUN:     if (!pcpi_valid) next_state = IDLE;
                     else if (last)   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    // iteration counter and latched op
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctr  <= '0;
            op_q <= OP_MUL;
        end else if (load) begin
            ctr  <= '0;
            op_q <= dec_op;
        end else if (step) begin
            ctr  <= ctr + CTR_W'(STEP_BITS);
        end
    end

    // registered handshake outputs; rd only updates when a result retires
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b0;
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= '0;
        end else begin
            pcpi_wait  <= (next_state == RUN);
            pcpi_ready <= (state == DONE);
            pcpi_wr    <= (state == DONE);
            if (state == DONE)
                pcpi_rd <= (op_q == OP_MUL) ? acc[XLEN-1:0] : acc[2*XLEN-1:XLEN];
        end
    end

    seq_mul_dp #(.XLEN(XLEN)) u_dp (
        .clk    (clk),
        .resetn (resetn),
        .load   (load),
        .step   (step),
        .sext_a (sext_a),
        .sext_b (sext_b),
        .a      (pcpi_rs1),
        .b      (pcpi_rs2),
        .acc    (acc)
    );
endmodule

// File: tb/tb_pcpi_seq_mul.sv
// Self-checking bench for pcpi_seq_mul: scoreboard of expected rd values
// pushed at issue and popped when pcpi_ready pulses.
module tb_pcpi_seq_mul;
    localparam int XLEN = 32;
`ifdef SEQ_MUL_2BIT_EN
    localparam int LAT = XLEN + 1;
`else
    localparam int LAT = 2*XLEN + 1;
`endif

    logic            clk = 1'b0;
    logic            resetn;
    logic            pcpi_valid;
    logic [31:0]     pcpi_insn;
    logic [XLEN-1:0] pcpi_rs1, pcpi_rs2;
    logic            pcpi_wr, pcpi_wait, pcpi_ready;
    logic [XLEN-1:0] pcpi_rd;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pcpi_seq_mul #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready)
    );

    function automatic logic [31:0] insn_of(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // reference product built from the 64-bit '*' operator
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f3 != 3'b011 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
        eb = ((f3 == 3'b000 || f3 == 3'b001) && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
        p  = ea * eb;
        return (f3 == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input string name);
        int n;
        bit got;
        logic [31:0] e;
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = insn_of(f3); pcpi_rs1 = a; pcpi_rs2 = b;
        exp_q.push_back(expv);
        @(posedge clk); #1;
        total++;
        if (pcpi_wait !== 1'b1) begin
            bad++; $display("FAIL %s wait_after_accept got=%b want=1", name, pcpi_wait);
        end
        n = 0; got = 0;
        while (n < 200 && !got) begin
            @(posedge clk); #1;
            n++;
            if (pcpi_ready === 1'b1) got = 1;
        end
        pcpi_valid = 1'b0;
        total++;
        if (n != LAT) begin
            bad++; $display("FAIL %s latency got=%0d want=%0d", name, n, LAT);
        end
        e = exp_q.pop_front();
        total++;
        if (!got) begin
            bad++; $display("FAIL %s no_ready got=timeout want=%h", name, e);
        end else if (pcpi_rd !== e || pcpi_wr !== 1'b1) begin
            bad++; $display("FAIL %s rd got=%h wr=%b want=%h wr=1", name, pcpi_rd, pcpi_wr, e);
        end
        @(posedge clk); #1;
        total++;
        if (pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0 || pcpi_wait !== 1'b0) begin
            bad++; $display("FAIL %s single_pulse got ready=%b wr=%b wait=%b want=0", name, pcpi_ready, pcpi_wr, pcpi_wait);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({pcpi_wr, pcpi_wait, pcpi_ready} !== 3'b000 || pcpi_rd !== '0) begin
            bad++; $display("FAIL reset_state got wr/wait/ready=%b%b%b rd=%h want 0", pcpi_wr, pcpi_wait, pcpi_ready, pcpi_rd);
        end
        @(negedge clk); resetn = 1'b1;
    endtask

    task automatic test_basic();
        run_op(3'b000, 32'd7, 32'd6, 32'h0000_002A, "mul_7x6");
    endtask

    task automatic test_corners();
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        run_op(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "mul_min");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ones");
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_ones");
        run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ones");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [2:0]  f3;
        for (int i = 0; i < 8; i++) begin
            a  = $urandom;
            b  = $urandom;
            f3 = 3'(i % 4);
            run_op(f3, a, b, model(f3, a, b), "random");
        end
    endtask

    task automatic test_illegal();
        bit seen = 0;
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = insn_of(3'b100); pcpi_rs1 = 32'd100; pcpi_rs2 = 32'd7;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (pcpi_wait !== 1'b0 || pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0) seen = 1;
        end
        pcpi_valid = 1'b0;
        total++;
        if (seen) begin
            bad++; $display("FAIL div_ignored got=handshake_activity want=none");
        end
    endtask

    task automatic test_abort();
        bit seen = 0;
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = insn_of(3'b000); pcpi_rs1 = 32'd3; pcpi_rs2 = 32'hFFFF_FFFB;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        pcpi_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (pcpi_wait !== 1'b0) begin
            bad++; $display("FAIL abort_wait got=%b want=0", pcpi_wait);
        end
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0) seen = 1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL abort_no_ready got=ready want=none");
        end
        run_op(3'b000, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1, "mul_after_abort");
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = insn_of(3'b011); pcpi_rs1 = 32'h1234_5678; pcpi_rs2 = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        total++;
        if ({pcpi_wr, pcpi_wait, pcpi_ready} !== 3'b000 || pcpi_rd !== '0) begin
            bad++; $display("FAIL mid_reset got wr/wait/ready=%b%b%b rd=%h want 0", pcpi_wr, pcpi_wait, pcpi_ready, pcpi_rd);
        end
        @(negedge clk);
        pcpi_valid = 1'b0;
        resetn = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0 || pcpi_wait !== 1'b0) seen = 1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL stale_after_reset got=activity want=none");
        end
        run_op(3'b000, 32'd7, 32'd6, 32'h0000_002A, "mul_after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_illegal();
        test_abort();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
